// File: rtl/button_pkg.sv
// Shared definitions for the button event path: FSM state encoding and the
// default LED indication timing used by pulse_to_level.
package button_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_HOLD = 2'd1;
   localparam state_t S_GAP  = 2'd2;

   localparam int DEF_HOLD_CYCLES = 4;
   localparam int DEF_GAP_CYCLES  = 2;
   localparam int DEF_PEND_W      = 3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down counter that saturates at both ends; a blocked increment at the top
// raises a one-cycle overflow flag. Simultaneous inc and dec cancel.
module sat_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   input  logic         i_dec,
   output logic [W-1:0] o_cnt,
   output logic         o_overflow
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0] r_cnt;
   logic         r_overflow;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= 1'b0;
         if (i_inc && !i_dec) begin
            if (r_cnt == CNT_MAX) r_overflow <= 1'b1;
            else                  r_cnt      <= r_cnt + 1'b1;
         end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign o_cnt      = r_cnt;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/pulse_to_level.sv
// Stretches one-clock event pulses into HOLD_CYCLES-wide levels separated by at
// least GAP_CYCLES low cycles; events arriving mid-pulse are queued.
module pulse_to_level
   import button_pkg::*;
#(
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int PEND_W      = DEF_PEND_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pulse_in,
   output logic              level_out,
   output logic              busy,
   output logic [PEND_W-1:0] pend_cnt,
   output logic              overflow
);

   localparam int DUR_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
   localparam logic [DUR_W-1:0] DUR_HOLD = DUR_W'(HOLD_CYCLES);
   localparam logic [DUR_W-1:0] DUR_GAP  = DUR_W'(GAP_CYCLES);
   localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

   state_t           r_state;
   logic [DUR_W-1:0] r_dur;
   logic             r_level;
   logic             r_busy;

   state_t           w_state_nxt;
   logic [DUR_W-1:0] w_dur_nxt;
   logic             w_dur_last;
   logic             w_pend_any;
   logic             w_start_new;
   logic             w_consume;
   logic             w_inc;
   logic [PEND_W-1:0] w_pend_cnt;
   logic             w_overflow;

   assign w_dur_last = (r_dur == DUR_ONE);
   assign w_pend_any = (w_pend_cnt != '0);

   // An idle pulse with an empty queue starts HOLD directly; any other pulse is queued.
   assign w_start_new = (r_state == S_IDLE) && pulse_in && !w_pend_any;
   assign w_inc       = pulse_in && !w_start_new;
   assign w_consume   = w_pend_any &&
                        ((r_state == S_IDLE) || ((r_state == S_GAP) && w_dur_last));

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_dur_nxt   = (r_dur != '0) ? (r_dur - DUR_ONE) : r_dur;
      case (r_state)
         S_IDLE: begin
            w_dur_nxt = '0;
            if (pulse_in || w_pend_any) begin
               w_state_nxt = S_HOLD;
               w_dur_nxt   = DUR_HOLD;
            end
         end
         S_HOLD: begin
            if (w_dur_last) begin
               w_state_nxt = S_GAP;
               w_dur_nxt   = DUR_GAP;
            end
         end
         S_GAP: begin
            if (w_dur_last) begin
               if (w_pend_any) begin
                  w_state_nxt = S_HOLD;
                  w_dur_nxt   = DUR_HOLD;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_dur_nxt   = '0;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_dur_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_dur   <= '0;
         r_level <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dur   <= w_dur_nxt;
         r_level <= (w_state_nxt == S_HOLD);
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   sat_counter #(
      .W (PEND_W)
   ) u_pend (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_inc      (w_inc),
      .i_dec      (w_consume),
      .o_cnt      (w_pend_cnt),
      .o_overflow (w_overflow)
   );

   assign level_out = r_level;
   assign busy      = r_busy;
   assign pend_cnt  = w_pend_cnt;
   assign overflow  = w_overflow;

endmodule
